ins_encode_loader: RTL and testbench
====================================

// Module: ins_encode_loader
// PURPOSE
//  Encoder side of the instruction format: takes decoded fields (opcode, rd, rs1, rs2, 32-bit imm)
//  over a valid/ready stream, range-checks the immediate, packs a 32-bit instruction word and writes it
//  sequentially into instruction memory. Used by the boot/test loader ahead of IF; its output words
//  must decode back to the same immediate in the ID-stage immediate generator.
// PARAMETERS
//  ADDR_W   8    instruction-memory word-address width
//  DEPTH    256  words available from base_addr (last writable = base_addr+DEPTH-1, no wrap)
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       synchronous, active-low reset
//  start      in   1       1-cycle pulse: begin program load (honoured only in IDLE/DONE/ERR)
//  base_addr  in   ADDR_W  first write address, sampled on start
//  in_valid   in   1       field tuple valid
//  in_ready   out  1       high only in RECV
//  in_opcode  in   5       instruction opcode -> word[4:0]
//  in_rd      in   5       -> word[11:7] (non-S/B formats)
//  in_rs1     in   5       -> word[19:15] (formats without imm20)
//  in_rs2     in   5       -> word[24:20] (R/S/B formats)
//  in_imm     in   32      signed/unsigned immediate per opcode
//  in_last    in   1       tuple is final instruction of program
//  mem_we     out  1       1-cycle write strobe
//  mem_addr   out  ADDR_W  write address
//  mem_wdata  out  32      encoded instruction
//  busy       out  1       state in RECV/ENC/WRITE
//  done       out  1       sticky until next start; program written without error
//  err        out  1       sticky until next start
//  err_code   out  2       0 none, 1 imm range, 2 memory full
//  count      out  ADDR_W+1  instructions written this load
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state IDLE; in_ready,mem_we,busy,done,err=0; err_code=0; count=0;
//   mem_addr=0; mem_wdata=0. Reset mid-load abandons the load; no further write is issued.
//  FSM: IDLE -start-> RECV; RECV -(in_valid&in_ready)-> ENC (fields+last captured);
//   ENC -imm ok-> WRITE, -imm bad-> ERR(code 1, no write);
//   WRITE: mem_we=1 one cycle, count++, ptr++; then DONE if last, ERR(code 2) if ptr was
//   base+DEPTH-1 and not last, else RECV. DONE/ERR -start-> RECV (clears done/err/count, reloads ptr).
//   start in RECV/ENC/WRITE is ignored.
//  Latency: tuple accepted at edge N -> mem_we high in cycle N+2; max throughput 1 word / 3 cycles.
//  Bits [6:5] and [14:12] always 0. Encoding and legal imm per opcode:
//   00010 addi, 01111 lw, 10100 jalr: [31:20]=imm[11:0]; imm in -2048..2047
//   00101 andi, 00111 ori, 01001 xori: [31:20]=imm[11:0]; imm in 0..4095
//   01011 slli, 01101 srli: [31:26]=0, [25:20]=imm[5:0]; imm in 0..63
//   01110 lui: [31:12]=imm[31:12]; imm[11:0] must be 0
//   10000 sw, 10001 blt, 10010 beq: [31:25]=imm[11:5], [11:7]=imm[4:0], rs1/rs2 placed; -2048..2047
//   10011 jal: [31:12]=imm[19:0], rd placed; imm in -524288..524287
//   any other opcode: R-format {7'b0,rs2,rs1,3'b0,rd,2'b0,opcode}; imm ignored, never an error
//  mem_addr/mem_wdata registered, stable through WRITE cycle; hold last value otherwise.
//  count saturates at DEPTH by construction (full check precedes overflow).
// STRUCTURE
//  Shared package: 5-bit opcode constants, err_code values, FSM state enum.
//  Sub-module ins_field_pack: combinational pack + range check (fields in -> word, imm_ok out);
//  this module owns FSM, pointer, counter and registered memory outputs.
// TESTING
//  addi rd=1 rs1=0 imm=-1, last -> mem_wdata=32'hFFF0_0082 at base, done=1, count=1
//  lui imm=32'h1234_5000 then sw rs1=2 rs2=3 imm=-4, last -> 32'h1234_500E, 32'hFE31_0E10
//  andi imm=4096 -> err=1, err_code=1, no mem_we; next start recovers, count=0
//  DEPTH=4, base=0, 5 tuples none last -> 4 writes (addr 0..3), err_code=2, in_ready low
//  rst_n low during ENC -> no mem_we follows, all outputs at reset values next cycle
//  in_valid held while ENC/WRITE -> only one accept per 3 cycles, no tuple duplicated or dropped

Source files
------------

// File: rtl/ins_encode_loader_pkg.sv
// Shared definitions for the instruction encoder/loader: opcodes, error codes, FSM states.
package ins_encode_loader_pkg;

    localparam logic [4:0] OP_ADDI = 5'b00010;
    localparam logic [4:0] OP_LW   = 5'b01111;
    localparam logic [4:0] OP_JALR = 5'b10100;
    localparam logic [4:0] OP_ANDI = 5'b00101;
    localparam logic [4:0] OP_ORI  = 5'b00111;
    localparam logic [4:0] OP_XORI = 5'b01001;
    localparam logic [4:0] OP_SLLI = 5'b01011;
    localparam logic [4:0] OP_SRLI = 5'b01101;
    localparam logic [4:0] OP_LUI  = 5'b01110;
    localparam logic [4:0] OP_SW   = 5'b10000;
    localparam logic [4:0] OP_BLT  = 5'b10001;
    localparam logic [4:0] OP_BEQ  = 5'b10010;
    localparam logic [4:0] OP_JAL  = 5'b10011;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_IMM  = 2'd1;
    localparam logic [1:0] ERR_FULL = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StEnc,
        StWrite,
        StDone,
        StErr
    } state_e;

endpackage

// File: rtl/ins_field_pack.sv
// Combinational instruction packer: places decoded fields into a 32-bit word and
// reports whether the immediate is representable for the given opcode.
module ins_field_pack
    import ins_encode_loader_pkg::*;
(
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        imm_ok
);

    logic signed [31:0] simm;
    logic               fits_s12;
    logic               fits_u12;
    logic               fits_u6;
    logic               fits_s20;
    logic               low12_zero;

    assign simm       = imm;
    assign fits_s12   = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    assign fits_u12   = (imm[31:12] == 20'd0);
    assign fits_u6    = (imm[31:6] == 26'd0);
    assign fits_s20   = (simm >= -32'sd524288) && (simm <= 32'sd524287);
    assign low12_zero = (imm[11:0] == 12'd0);

    always_comb begin
        // Unknown opcodes fall back to R-format and never flag an error.
        word   = {7'b0, rs2, rs1, 3'b0, rd, 2'b0, opcode};
        imm_ok = 1'b1;
        case (opcode)
            OP_ADDI, OP_LW, OP_JALR: begin
                word   = {imm[11:0], rs1, 3'b0, rd, 2'b0, opcode};
                imm_ok = fits_s12;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                word   = {imm[11:0], rs1, 3'b0, rd, 2'b0, opcode};
                imm_ok = fits_u12;
            end
            OP_SLLI, OP_SRLI: begin
                word   = {6'b0, imm[5:0], rs1, 3'b0, rd, 2'b0, opcode};
                imm_ok = fits_u6;
            end
            OP_LUI: begin
                word   = {imm[31:12], rd, 2'b0, opcode};
                imm_ok = low12_zero;
            end
            OP_SW, OP_BLT, OP_BEQ: begin
                word   = {imm[11:5], rs2, rs1, 3'b0, imm[4:0], 2'b0, opcode};
                imm_ok = fits_s12;
            end
            OP_JAL: begin
                word   = {imm[19:0], rd, 2'b0, opcode};
                imm_ok = fits_s20;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ins_encode_loader.sv
// Program loader: accepts field tuples, encodes them and writes words sequentially
// into instruction memory starting at base_addr.
module ins_encode_loader
    import ins_encode_loader_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] LAST_SLOT = (ADDR_W + 1)'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        err_code_q;
    logic [4:0]        opcode_q, rd_q, rs1_q, rs2_q;
    logic [31:0]       imm_q;
    logic              last_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       word;
    logic              imm_ok;
    logic              at_end;

    ins_field_pack u_pack (
        .opcode (opcode_q),
        .rd     (rd_q),
        .rs1    (rs1_q),
        .rs2    (rs2_q),
        .imm    (imm_q),
        .word   (word),
        .imm_ok (imm_ok)
    );

    // Slot count rather than pointer compare, so base_addr near the top cannot alias.
    assign at_end = (count_q == LAST_SLOT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: if (start) state_d = StRecv;
            StRecv:  if (in_valid) state_d = StEnc;
            StEnc:   state_d = imm_ok ? StWrite : StErr;
            StWrite: begin
                if (last_q)      state_d = StDone;
                else if (at_end) state_d = StErr;
                else             state_d = StRecv;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            count_q     <= '0;
            err_code_q  <= ERR_NONE;
            opcode_q    <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            last_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        ptr_q      <= base_addr;
                        count_q    <= '0;
                        err_code_q <= ERR_NONE;
                    end
                end
                StRecv: begin
                    if (in_valid) begin
                        opcode_q <= in_opcode;
                        rd_q     <= in_rd;
                        rs1_q    <= in_rs1;
                        rs2_q    <= in_rs2;
                        imm_q    <= in_imm;
                        last_q   <= in_last;
                    end
                end
                StEnc: begin
                    if (imm_ok) begin
                        mem_addr_q  <= ptr_q;
                        mem_wdata_q <= word;
                    end else begin
                        err_code_q <= ERR_IMM;
                    end
                end
                StWrite: begin
                    ptr_q   <= ptr_q + ADDR_W'(1);
                    count_q <= count_q + (ADDR_W + 1)'(1);
                    if (!last_q && at_end) err_code_q <= ERR_FULL;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StRecv);
    assign mem_we    = (state_q == StWrite);
    assign busy      = (state_q == StRecv) || (state_q == StEnc) || (state_q == StWrite);
    assign done      = (state_q == StDone);
    assign err       = (state_q == StErr);
    assign err_code  = err_code_q;
    assign count     = count_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_ins_encode_loader.sv
// Directed bench for ins_encode_loader with a write scoreboard (DEPTH reduced to 4).
module tb_ins_encode_loader;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid, in_ready, in_last;
    logic [ADDR_W-1:0] base_addr;
    logic [4:0]        in_opcode, in_rd, in_rs1, in_rs2;
    logic [31:0]       in_imm;
    logic              mem_we, busy, done, err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        err_code;
    logic [ADDR_W:0]   count;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t               sb[$];
    logic [ADDR_W-1:0] exp_ptr;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                acc_cyc = 0;
    int                first_acc;

    ins_encode_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_imm    (in_imm),
        .in_last   (in_last),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Every observed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_write: got addr %h data %h expected no write",
                       mem_addr, mem_wdata);
            end
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.data);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                        input logic [31:0] exp_word, input bit wr, input bit hold);
        bit ok;
        ok        = 1'b0;
        in_valid  = 1'b1;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm    = imm;
        in_last   = last;
        for (int i = 0; i < 12; i++) begin
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("accept", 32'(ok), 32'd1);
        if (ok) begin
            acc_cyc = cyc;
            if (wr) begin
                sb.push_back({exp_ptr, exp_word});
                exp_ptr = exp_ptr + 1'b1;
            end
            @(negedge clk);
        end
        if (!hold || !ok) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy !== 1'b0; i++) @(negedge clk);
        check("idle", 32'(busy), 32'd0);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
        exp_ptr = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_code", 32'(err_code), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single addi, last.
        do_start(8'h10); exp_ptr = 8'h10;
        send(5'b00010, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 32'hFFF0_0082, 1'b1, 1'b0);
        wait_idle();
        check("t1_done", 32'(done), 32'd1);
        check("t1_err", 32'(err), 32'd0);
        check("t1_count", 32'(count), 32'd1);
        check("t1_hold_addr", 32'(mem_addr), 32'h10);
        check("t1_hold_data", mem_wdata, 32'hFFF0_0082);
        check("t1_sb_empty", 32'(sb.size()), 32'd0);

        // lui + sw; a start pulse while loading must be ignored.
        do_start(8'h20); exp_ptr = 8'h20;
        do_start(8'h70);
        send(5'b01110, 5'd0, 5'd7, 5'd0, 32'h1234_5000, 1'b0, 32'h1234_500E, 1'b1, 1'b0);
        send(5'b10000, 5'd9, 5'd2, 5'd3, 32'hFFFF_FFFC, 1'b1, 32'hFE31_0E10, 1'b1, 1'b0);
        wait_idle();
        check("t2_done", 32'(done), 32'd1);
        check("t2_count", 32'(count), 32'd2);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        // andi out of range, then recovery.
        do_start(8'h30); exp_ptr = 8'h30;
        send(5'b00101, 5'd1, 5'd1, 5'd0, 32'd4096, 1'b1, 32'h0, 1'b0, 1'b0);
        wait_idle();
        check("t3_err", 32'(err), 32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        check("t3_done", 32'(done), 32'd0);
        check("t3_count", 32'(count), 32'd0);
        check("t3_nowrite", mem_wdata, 32'hFE31_0E10);
        do_start(8'h30); exp_ptr = 8'h30;
        check("t3_clr_err", 32'(err), 32'd0);
        check("t3_clr_code", 32'(err_code), 32'd0);
        check("t3_clr_count", 32'(count), 32'd0);
        check("t3_ready", 32'(in_ready), 32'd1);
        send(5'b00101, 5'd0, 5'd0, 5'd0, 32'd4095, 1'b1, 32'hFFF0_0005, 1'b1, 1'b0);
        wait_idle();
        check("t3_done2", 32'(done), 32'd1);
        check("t3_count2", 32'(count), 32'd1);

        // Memory full at DEPTH=4 from base 0.
        do_start(8'h00); exp_ptr = 8'h00;
        send(5'b01011, 5'd3, 5'd4, 5'd0, 32'd5, 1'b0, 32'h0052_018B, 1'b1, 1'b0);
        send(5'b10011, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFE, 1'b0, 32'hFFFF_E093, 1'b1, 1'b0);
        send(5'b00001, 5'd4, 5'd5, 5'd6, 32'hDEAD_BEEF, 1'b0, 32'h0062_8201, 1'b1, 1'b0);
        send(5'b10010, 5'd0, 5'd1, 5'd2, 32'd2047, 1'b0, 32'h7E20_8F92, 1'b1, 1'b0);
        wait_idle();
        check("t4_err", 32'(err), 32'd1);
        check("t4_code", 32'(err_code), 32'd2);
        check("t4_count", 32'(count), 32'd4);
        check("t4_done", 32'(done), 32'd0);
        in_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_ready", 32'(in_ready), 32'd0);
        check("t4_count2", 32'(count), 32'd4);
        in_valid = 1'b0;
        check("t4_sb_empty", 32'(sb.size()), 32'd0);

        // in_valid held across ENC/WRITE: one accept per 3 cycles.
        do_start(8'h40); exp_ptr = 8'h40;
        send(5'b01001, 5'd2, 5'd3, 5'd0, 32'h0AB, 1'b0, 32'h0AB1_8109, 1'b1, 1'b1);
        first_acc = acc_cyc;
        send(5'b01101, 5'd7, 5'd8, 5'd0, 32'd63, 1'b0, 32'h03F4_038D, 1'b1, 1'b1);
        send(5'b01111, 5'd5, 5'd6, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8003_028F, 1'b1, 1'b0);
        check("t5_spacing", 32'(acc_cyc - first_acc), 32'd6);
        wait_idle();
        check("t5_done", 32'(done), 32'd1);
        check("t5_count", 32'(count), 32'd3);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Reset while in ENC abandons the write.
        do_start(8'h50); exp_ptr = 8'h50;
        send(5'b00010, 5'd1, 5'd1, 5'd0, 32'd1, 1'b1, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_we", 32'(mem_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_ready", 32'(in_ready), 32'd0);
        check("t6_count", 32'(count), 32'd0);
        check("t6_addr", 32'(mem_addr), 32'd0);
        check("t6_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);
        check("t6_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
